// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory load/store path: format codes (same
// encoding the downstream load extender decodes), byte-enable patterns and
// controller state encodings.
package dmem_pkg;

    typedef logic [2:0] fmt_t;

    localparam fmt_t FMT_B  = 3'b000;
    localparam fmt_t FMT_H  = 3'b001;
    localparam fmt_t FMT_W  = 3'b010;
    localparam fmt_t FMT_BU = 3'b011;
    localparam fmt_t FMT_HU = 3'b100;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for a 32-bit data port: byte enables and store-data
// replication from format + low address bits, right-alignment and masking of
// read data, and detection of misaligned or illegal format/direction combos.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  fmt_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        we_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [31:0] shifted;

    // Decode lanes per format; unsupported codes are flagged and drive no lanes.
    always_comb begin
        shifted    = rdata_i >> {addr_lo_i, 3'b000};
        be_o       = 4'b0000;
        wdata_o    = 32'h0;
        rdata_o    = 32'h0;
        misalign_o = 1'b0;
        case (fmt_i)
            FMT_B, FMT_BU: begin
                be_o    = BE_BYTE << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {24'h0, shifted[7:0]};
            end
            FMT_H, FMT_HU: begin
                be_o       = BE_HALF << addr_lo_i;
                wdata_o    = {2{wdata_i[15:0]}};
                rdata_o    = {16'h0, shifted[15:0]};
                misalign_o = addr_lo_i[0];
            end
            FMT_W: begin
                be_o       = BE_WORD;
                wdata_o    = wdata_i;
                rdata_o    = rdata_i;
                misalign_o = (addr_lo_i != 2'b00);
            end
            default: misalign_o = 1'b1;
        endcase
        // Unsigned formats only make sense for loads.
        if (we_i && (fmt_i == FMT_BU || fmt_i == FMT_HU)) begin
            misalign_o = 1'b1;
        end
        if (misalign_o) begin
            be_o = 4'b0000;
        end
    end

endmodule

// File: rtl/dmem_load_store_ctrl.sv
// Data-memory access controller: takes one MEM-stage load/store per handshake,
// rejects misaligned/illegal requests without touching memory, runs a single
// word-addressed access with a bounded wait for mem_ack, and returns
// right-aligned (unextended) load data plus the format code for the extender.
module dmem_load_store_ctrl
    import dmem_pkg::*;
#(
    parameter int WIDTH_DATA_LENGTH = 32,
    parameter int LENGTH_MUX        = 3,
    parameter int ADDR_WIDTH        = 32,
    parameter int WAIT_MAX          = 15
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [ADDR_WIDTH-1:0]        req_addr,
    input  logic [WIDTH_DATA_LENGTH-1:0] req_wdata,
    input  logic [LENGTH_MUX-1:0]        req_fmt,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic [3:0]                   mem_be,
    output logic [WIDTH_DATA_LENGTH-1:0] mem_wdata,
    input  logic                         mem_ack,
    input  logic [WIDTH_DATA_LENGTH-1:0] mem_rdata,
    output logic                         rsp_valid,
    output logic [WIDTH_DATA_LENGTH-1:0] rsp_data,
    output logic [LENGTH_MUX-1:0]        rsp_fmt,
    output logic                         rsp_misalign,
    output logic                         rsp_timeout
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    state_e                         state_q;
    logic                           we_q;
    logic [1:0]                     addr_lo_q;
    logic [LENGTH_MUX-1:0]          fmt_q;
    logic [CW-1:0]                  wait_cnt_q, wait_cnt_d;

    logic                           mem_req_q, mem_we_q;
    logic [ADDR_WIDTH-1:0]          mem_addr_q;
    logic [3:0]                     mem_be_q;
    logic [WIDTH_DATA_LENGTH-1:0]   mem_wdata_q;
    logic                           rsp_valid_q, rsp_misalign_q, rsp_timeout_q;
    logic [WIDTH_DATA_LENGTH-1:0]   rsp_data_q;
    logic [LENGTH_MUX-1:0]          rsp_fmt_q;

    logic [2:0]                     sel_fmt;
    logic [1:0]                     sel_lo;
    logic                           sel_we;
    logic [3:0]                     lane_be;
    logic [31:0]                    lane_wdata, lane_rdata;
    logic                           lane_misalign;

    // One aligner serves both phases: live request fields in IDLE (lanes and
    // misalign check), latched fields in ACCESS (read-data alignment).
    always_comb begin
        sel_fmt    = (state_q == IDLE) ? req_fmt       : fmt_q;
        sel_lo     = (state_q == IDLE) ? req_addr[1:0] : addr_lo_q;
        sel_we     = (state_q == IDLE) ? req_we        : we_q;
        wait_cnt_d = wait_cnt_q + 1'b1;
    end

    dmem_lane_align u_align (
        .fmt_i      (sel_fmt),
        .addr_lo_i  (sel_lo),
        .we_i       (sel_we),
        .wdata_i    (req_wdata),
        .rdata_i    (mem_rdata),
        .be_o       (lane_be),
        .wdata_o    (lane_wdata),
        .rdata_o    (lane_rdata),
        .misalign_o (lane_misalign)
    );

    // Controller FSM with registered memory-port and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            we_q           <= 1'b0;
            addr_lo_q      <= 2'b00;
            fmt_q          <= '0;
            wait_cnt_q     <= '0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_be_q       <= 4'b0000;
            mem_wdata_q    <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= '0;
            rsp_fmt_q      <= '0;
            rsp_misalign_q <= 1'b0;
            rsp_timeout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q       <= req_we;
                        addr_lo_q  <= req_addr[1:0];
                        fmt_q      <= req_fmt;
                        rsp_fmt_q  <= req_fmt;
                        wait_cnt_q <= '0;
                        if (lane_misalign) begin
                            // Rejected before memory sees it.
                            rsp_valid_q    <= 1'b1;
                            rsp_misalign_q <= 1'b1;
                            rsp_data_q     <= '0;
                            state_q        <= RESP;
                        end else begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= req_we;
                            mem_addr_q  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                            mem_be_q    <= lane_be;
                            mem_wdata_q <= lane_wdata;
                            state_q     <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_be_q    <= 4'b0000;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= we_q ? '0 : lane_rdata;
                        state_q     <= RESP;
                    end else if (wait_cnt_d == CW'(WAIT_MAX)) begin
                        // Give up: memory never answered within the budget.
                        mem_req_q     <= 1'b0;
                        mem_we_q      <= 1'b0;
                        mem_be_q      <= 4'b0000;
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_data_q    <= '0;
                        state_q       <= RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                    end
                end
                RESP: begin
                    rsp_valid_q    <= 1'b0;
                    rsp_misalign_q <= 1'b0;
                    rsp_timeout_q  <= 1'b0;
                    rsp_data_q     <= '0;
                    state_q        <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_be       = mem_be_q;
    assign mem_wdata    = mem_wdata_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_fmt      = rsp_fmt_q;
    assign rsp_misalign = rsp_misalign_q;
    assign rsp_timeout  = rsp_timeout_q;

endmodule

// File: tb/tb_dmem_load_store_ctrl.sv
// Bench for dmem_load_store_ctrl: directed requests against a small memory
// model, expected responses queued at accept time and compared on rsp_valid.
module tb_dmem_load_store_ctrl;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_fmt;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        rsp_valid, rsp_misalign, rsp_timeout;
    logic [31:0] rsp_data;
    logic [2:0]  rsp_fmt;

    logic        ack_en, ack_force, ack_resp;
    logic [31:0] tb_mem [256];
    int          n_chk = 0, n_err = 0, cyc = 0;

    typedef struct {
        logic [31:0] data;
        logic [31:0] ext;
        logic [2:0]  fmt;
        logic        mis;
        logic        to;
        int          acc;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    dmem_load_store_ctrl #(.WAIT_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_fmt(req_fmt),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_fmt(rsp_fmt),
        .rsp_misalign(rsp_misalign), .rsp_timeout(rsp_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: acks any pending strobe (when enabled), data by word address.
    always @(negedge clk) ack_resp = mem_req & ack_en;
    assign mem_ack   = ack_resp | ack_force;
    assign mem_rdata = tb_mem[mem_addr[9:2]];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference load extender fed by rsp_data/rsp_fmt.
    function automatic logic [31:0] ext(input logic [31:0] d, input logic [2:0] f);
        case (f)
            FMT_B:   ext = {{24{d[7]}}, d[7:0]};
            FMT_H:   ext = {{16{d[15]}}, d[15:0]};
            FMT_BU:  ext = {24'h0, d[7:0]};
            FMT_HU:  ext = {16'h0, d[15:0]};
            default: ext = d;
        endcase
    endfunction

    function automatic exp_t mk(input logic [31:0] d, input logic [31:0] x, input logic [2:0] f,
                                input logic m, input logic t, input int lat);
        exp_t e;
        e.data = d; e.ext = x; e.fmt = f; e.mis = m; e.to = t; e.acc = 0; e.lat = lat;
        return e;
    endfunction

    // Scoreboard: every rsp_valid cycle consumes one expected response.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sb_q.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_ext", ext(rsp_data, rsp_fmt), e.ext);
                chk("rsp_fmt", 32'(rsp_fmt), 32'(e.fmt));
                chk("rsp_misalign", 32'(rsp_misalign), 32'(e.mis));
                chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
                chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] fmt,
                          input bit push, input exp_t e);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_fmt = fmt;
        chk({tag, "_ready"}, 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (push) begin
            e.acc = cyc;
            sb_q.push_back(e);
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        #1;
        chk({tag, "_drain"}, 32'(sb_q.size()), 32'h0);
    endtask

    exp_t dummy, e;
    int   n;

    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] = 32'h0;
        tb_mem[0]  = 32'h1234_9ABC;
        tb_mem[1]  = 32'hCAFE_F00D;
        tb_mem[4]  = 32'h8001_5555;
        tb_mem[8]  = 32'hDEAD_BEEF;
        tb_mem[64] = 32'h80AA_BBCC;
        dummy = mk(0, 0, 0, 0, 0, 0);
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 0; req_wdata = 0;
        req_fmt = 0; ack_en = 1'b0; ack_force = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'h1);
        chk("rst_memreq", 32'(mem_req), 32'h0);
        chk("rst_memwe", 32'(mem_we), 32'h0);
        chk("rst_membe", 32'(mem_be), 32'h0);
        chk("rst_memaddr", mem_addr, 32'h0);
        chk("rst_memwdata", mem_wdata, 32'h0);
        chk("rst_rspvalid", 32'(rsp_valid), 32'h0);
        chk("rst_rspdata", rsp_data, 32'h0);
        rst = 1'b0;

        // Reset while an access is outstanding; later ack must be ignored.
        do_req("rstacc", 1'b0, 32'h10, 32'h0, FMT_W, 1'b0, dummy);
        @(negedge clk);
        chk("rstacc_memreq_on", 32'(mem_req), 32'h1);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rstacc_memreq", 32'(mem_req), 32'h0);
            chk("rstacc_rspvalid", 32'(rsp_valid), 32'h0);
        end
        rst = 1'b0; ack_force = 1'b1;
        @(negedge clk);
        ack_force = 1'b0;
        chk("rstacc_ready", 32'(req_ready), 32'h1);
        chk("rstacc_memreq_idle", 32'(mem_req), 32'h0);
        repeat (2) @(negedge clk);

        ack_en = 1'b1;
        // LB at byte 3: sign bit set in the addressed byte.
        do_req("lb", 1'b0, 32'h103, 32'h0, FMT_B, 1'b1, mk(32'h80, 32'hFFFF_FF80, FMT_B, 0, 0, 1));
        @(negedge clk);
        chk("lb_memreq", 32'(mem_req), 32'h1);
        chk("lb_memwe", 32'(mem_we), 32'h0);
        chk("lb_memaddr", mem_addr, 32'h100);
        chk("lb_membe", 32'(mem_be), 32'h8);
        chk("lb_ready", 32'(req_ready), 32'h0);
        drain("lb");

        // SH at upper half.
        do_req("sh", 1'b1, 32'h202, 32'h1234_ABCD, FMT_H, 1'b1, mk(0, 0, FMT_H, 0, 0, 1));
        @(negedge clk);
        chk("sh_memreq", 32'(mem_req), 32'h1);
        chk("sh_memwe", 32'(mem_we), 32'h1);
        chk("sh_memaddr", mem_addr, 32'h200);
        chk("sh_membe", 32'(mem_be), 32'hC);
        chk("sh_memwdata", mem_wdata, 32'hABCD_ABCD);
        drain("sh");

        // More aligned loads across lanes and formats.
        do_req("lh", 1'b0, 32'h12, 32'h0, FMT_H, 1'b1, mk(32'h8001, 32'hFFFF_8001, FMT_H, 0, 0, 1));
        drain("lh");
        do_req("lbu", 1'b0, 32'h101, 32'h0, FMT_BU, 1'b1, mk(32'hBB, 32'hBB, FMT_BU, 0, 0, 1));
        @(negedge clk);
        chk("lbu_membe", 32'(mem_be), 32'h2);
        drain("lbu");
        do_req("lw", 1'b0, 32'h20, 32'h0, FMT_W, 1'b1, mk(32'hDEAD_BEEF, 32'hDEAD_BEEF, FMT_W, 0, 0, 1));
        drain("lw");

        // Misaligned / illegal requests never reach memory.
        do_req("lwmis", 1'b0, 32'h101, 32'h0, FMT_W, 1'b1, mk(0, 0, FMT_W, 1, 0, 0));
        @(negedge clk);
        chk("lwmis_memreq", 32'(mem_req), 32'h0);
        drain("lwmis");
        do_req("shu", 1'b1, 32'h0, 32'hFFFF, FMT_HU, 1'b1, mk(0, 0, FMT_HU, 1, 0, 0));
        @(negedge clk);
        chk("shu_memreq", 32'(mem_req), 32'h0);
        drain("shu");
        do_req("fmt5", 1'b0, 32'h0, 32'h0, 3'b101, 1'b1, mk(0, 0, 3'b101, 1, 0, 0));
        @(negedge clk);
        chk("fmt5_memreq", 32'(mem_req), 32'h0);
        drain("fmt5");

        // Timeout with no ack, then a late ack that must be ignored.
        ack_en = 1'b0;
        do_req("to", 1'b0, 32'h40, 32'h0, FMT_W, 1'b1, mk(0, 0, FMT_W, 0, 1, 4));
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mem_req) n++;
        end
        ack_force = 1'b1;
        repeat (2) @(negedge clk);
        ack_force = 1'b0;
        chk("to_reqcycles", 32'(n), 32'h4);
        chk("to_ready", 32'(req_ready), 32'h1);
        drain("to");

        // Back-to-back with req_valid held high.
        ack_en = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0; req_fmt = FMT_HU;
        chk("b2b_ready0", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        e = mk(32'h9ABC, 32'h9ABC, FMT_HU, 0, 0, 1); e.acc = cyc; sb_q.push_back(e);
        req_addr = 32'h4; req_fmt = FMT_W;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (req_ready) break;
            n++;
        end
        chk("b2b_notready", 32'(n), 32'h2);
        chk("b2b_first_done", 32'(sb_q.size()), 32'h0);
        @(posedge clk); #1;
        e = mk(32'hCAFE_F00D, 32'hCAFE_F00D, FMT_W, 0, 0, 1); e.acc = cyc; sb_q.push_back(e);
        req_valid = 1'b0;
        drain("b2b");

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        chk("watchdog", 32'h1, 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
